reload_sequencer: RTL

- Command-driven reload controller that sits directly upstream of the 8-bit down counter.
- Queues interval commands of the form (period, repeat), drives the counter's load/preload inputs, and watches its zero flag.
- Emits per-interval and per-command completion pulses to the timer/interrupt logic.
- Lets software schedule back-to-back timed intervals without cycle-exact reload handling.

---
 rtl/reload_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reload_sequencer.sv
// Command-queued reload controller for the 8-bit down counter: pops (period, repeat) entries and sequences LOAD/ARM/WAIT.
// Optional RELOAD_SEQ_STATS_EN adds a 16-bit done_count of completed intervals.
module reload_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_period,
  input  logic [3:0]    cmd_repeat,
  input  logic          abort,
  output logic          cnt_load,
  output logic [7:0]    cnt_preload,
  input  logic          cnt_zero,
  output logic          interval_done,
  output logic          cmd_done,
  output logic          busy,
  output logic [AW:0]   fifo_level
`ifdef RELOAD_SEQ_STATS_EN
  ,
  output logic [15:0]   done_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ARM  = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [11:0]   mem_q [DEPTH];
  logic [11:0]   mem_d [DEPTH];
  logic [7:0]    cur_period_q, cur_period_d;
  logic [3:0]    rep_left_q, rep_left_d;
  logic          fifo_empty, fifo_full, push, pop;

  assign fifo_empty  = (level_q == {(AW+1){1'b0}});
  assign fifo_full   = (level_q == LVL_FULL);
  assign cmd_ready   = !fifo_full && !abort;
  assign push        = cmd_valid && cmd_ready;
  assign cnt_load    = (state_q == S_LOAD);
  assign cnt_preload = cur_period_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_level  = level_q;

  // Sequencer next state, entry latch and completion pulses; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    cur_period_d  = cur_period_q;
    rep_left_d    = rep_left_q;
    pop           = 1'b0;
    interval_done = 1'b0;
    cmd_done      = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop                        = 1'b1;
            {cur_period_d, rep_left_d} = mem_q[rd_ptr_q];
            state_d                    = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: state_d = S_ARM;
        // Counter still shows the old value here, so its zero flag is meaningless.
        S_ARM:  state_d = S_WAIT;
        S_WAIT: begin
          if (cnt_zero) begin
            interval_done = 1'b1;
            if (rep_left_q == 4'd0) begin
              cmd_done = 1'b1;
              state_d  = S_IDLE;
            end else begin
              rep_left_d = rep_left_q - 4'd1;
              state_d    = S_LOAD;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Command FIFO pointers, occupancy and storage; abort flushes and blocks the push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {(AW+1){1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {cmd_period, cmd_repeat};
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // State, FIFO and entry registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= {(AW+1){1'b0}};
      cur_period_q <= 8'h00;
      rep_left_q   <= 4'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 12'h000;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      cur_period_q <= cur_period_d;
      rep_left_q   <= rep_left_d;
      mem_q        <= mem_d;
    end
  end

`ifdef RELOAD_SEQ_STATS_EN
  logic [15:0] done_count_q, done_count_d;

  // Interval counter wraps naturally; only nrst clears it.
  always_comb begin
    if (interval_done) begin
      done_count_d = done_count_q + 16'd1;
    end else begin
      done_count_d = done_count_q;
    end
  end

  // Interval counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_count_q <= 16'h0000;
    end else begin
      done_count_q <= done_count_d;
    end
  end

  assign done_count = done_count_q;
`endif

endmodule
